// File: rtl/mult_operand_feeder.sv
// Operand FIFO and result collector for the 10-stage sequential 8x8 multiplier.
// Tracks the multiplier stage locally so operands land exactly at stage 0 and products are taken at stage 9.
module mult_operand_feeder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             mul_rst,
  output logic [7:0]       mul_in1,
  output logic [7:0]       mul_in2,
  input  logic [15:0]      mul_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [CNT_W-1:0] fifo_count
);
  localparam int AW = $clog2(DEPTH);

  logic             r_mul_rst;
  logic [3:0]       r_phase;
  logic             r_busy;
  logic             r_res_valid;
  logic [15:0]      r_res_data;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_mem [DEPTH];

  logic        w_full;
  logic        w_push;
  logic        w_issue;
  logic        w_capture;
  logic        w_res_fire;
  logic [15:0] w_head;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_push     = in_valid && !w_full;
  assign w_head     = r_mem[r_rptr];
  // Only issue when the result register will be free before this job's capture.
  assign w_issue    = (r_phase == 4'd0) && !r_mul_rst && (r_count != '0) &&
                      (!r_res_valid || res_ready);
  assign w_capture  = (r_phase == 4'd9) && r_busy;
  assign w_res_fire = r_res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mul_rst   <= 1'b1;
      r_phase     <= 4'd0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= 16'd0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_mul_rst <= 1'b0;
      if (r_mul_rst || r_phase == 4'd9) r_phase <= 4'd0;
      else                              r_phase <= r_phase + 4'd1;
      if (w_push)  r_wptr <= r_wptr + 1'b1;
      if (w_issue) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_issue)      r_count <= r_count + 1'b1;
      else if (!w_push && w_issue) r_count <= r_count - 1'b1;
      if (w_issue)        r_busy <= 1'b1;
      else if (w_capture) r_busy <= 1'b0;
      if (w_res_fire) r_res_valid <= 1'b0;
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= mul_out;
      end
    end
  end

  assign in_ready   = !w_full;
  assign mul_rst    = r_mul_rst;
  assign mul_in1    = w_issue ? w_head[15:8] : 8'd0;
  assign mul_in2    = w_issue ? w_head[7:0]  : 8'd0;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign fifo_count = r_count;
endmodule

// File: tb/tb_mult_operand_feeder.sv
// Bench for mult_operand_feeder: behavioural 10-stage multiplier plus a timestamp/queue reference model.
module tb_mult_operand_feeder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'd0, in_b = 8'd0;
  logic        mul_rst;
  logic [7:0]  mul_in1, mul_in2;
  logic [15:0] mul_out;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_data;
  logic [CNT_W-1:0] fifo_count;

  int n_chk = 0;
  int n_err = 0;

  mult_operand_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_rst(mul_rst), .mul_in1(mul_in1),
    .mul_in2(mul_in2), .mul_out(mul_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: latches operands at stage 0, product valid only at stage 9.
  logic [3:0]  s_stage = 4'd0;
  logic [7:0]  s_a = 8'd0, s_b = 8'd0;
  always @(posedge clk) begin
    if (mul_rst) s_stage <= 4'd0;
    else begin
      s_stage <= (s_stage == 4'd9) ? 4'd0 : s_stage + 4'd1;
      if (s_stage == 4'd0) begin s_a <= mul_in1; s_b <= mul_in2; end
    end
  end
  assign mul_out = (s_stage == 4'd9) ? 16'(s_a) * 16'(s_b) : 16'h5A5A;

  // Reference model: operand queue, cycle count since the multiplier came out of reset, one job slot.
  logic [15:0] mq[$];
  bit          m_run = 0;
  int          m_t = 0;
  bit          m_rv = 0;
  logic [15:0] m_rd = 16'd0;
  bit          m_job = 0;
  int          m_job_t = 0;
  logic [15:0] m_job_p = 16'd0;

  always @(negedge rst) begin
    mq.delete();
    m_run = 0; m_t = 0; m_rv = 0; m_rd = 16'd0; m_job = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      int sz;
      bit iss;
      logic [15:0] h;
      sz  = mq.size();
      iss = m_run && (m_t % 10 == 0) && sz > 0 && (!m_rv || res_ready);
      if (m_rv && res_ready) m_rv = 0;
      if (m_run && m_job && m_t == m_job_t + 9) begin
        m_rv = 1; m_rd = m_job_p; m_job = 0;
      end
      if (in_valid && sz < DEPTH) mq.push_back({in_a, in_b});
      if (iss) begin
        h = mq.pop_front();
        m_job = 1; m_job_t = m_t; m_job_p = 16'(h[15:8]) * 16'(h[7:0]);
      end
      if (m_run) m_t++;
      else m_run = 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    bit eiss;
    #2;
    eiss = m_run && (m_t % 10 == 0) && mq.size() > 0 && (!m_rv || res_ready);
    chk("mul_rst",   mul_rst,   !m_run);
    chk("fifo_count", fifo_count, mq.size());
    chk("in_ready",  in_ready,  mq.size() < DEPTH);
    chk("res_valid", res_valid, m_rv);
    chk("res_data",  res_data,  m_rd);
    chk("mul_in1",   mul_in1,   eiss ? mq[0][15:8] : 8'd0);
    chk("mul_in2",   mul_in2,   eiss ? mq[0][7:0]  : 8'd0);
  end

  int peak = 0;
  bit seen_full = 0;
  always @(negedge clk) begin
    #3;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    if (!in_ready) seen_full = 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("push_timeout", n < 200, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input logic [15:0] exp);
    bit got;
    got = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      #1;
      if (res_valid) got = 1;
    end
    chk({tag, "_valid"}, got, 1);
    chk(tag, res_data, exp);
  endtask

  initial begin
    #1 rst = 1'b0;
    tick(3);
    #1;
    chk("rst_mul_rst", mul_rst, 1);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("mul_rst_one_edge", mul_rst, 0);
    @(negedge clk);

    push(8'd3, 8'd5);
    wait_res("p3x5", 16'h000F);
    push(8'd255, 8'd255);
    wait_res("p255x255", 16'hFE01);
    push(8'd0, 8'd200);
    wait_res("p0x200", 16'h0000);
    tick(12);

    peak = 0; seen_full = 0;
    for (int i = 0; i < 6; i++) push(8'(i * 17 + 1), 8'(i * 3 + 2));
    tick(70);
    chk("peak_count", peak, 4);
    chk("in_ready_dropped", seen_full, 1);

    res_ready = 1'b0;
    push(8'd7, 8'd9);
    push(8'd2, 8'd2);
    wait_res("p7x9", 16'h003F);
    tick(25);
    chk("stall_hold", res_data, 16'h003F);
    chk("stall_queued", fifo_count, 1);
    begin
      bit found;
      found = 0;
      for (int n = 0; n < 20 && !found; n++) begin
        @(negedge clk);
        if (m_run && m_t % 10 == 0) found = 1;
      end
      chk("phase0_found", found, 1);
    end
    res_ready = 1'b1;
    #1 chk("stall_issue_a", mul_in1, 8'd2);
    wait_res("p2x2", 16'h0004);
    tick(12);

    push(8'd12, 8'd12);
    begin
      bit found;
      found = 0;
      for (int n = 0; n < 40 && !found; n++) begin
        @(negedge clk);
        if (m_job && m_t == m_job_t + 5) found = 1;
      end
      chk("phase5_found", found, 1);
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_mul_rst", mul_rst, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(15);
    chk("lost_job_no_valid", res_valid, 0);
    push(8'd12, 8'd12);
    wait_res("p12x12", 16'h0090);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0; res_ready = 1'b1;
    tick(80);
    chk("drained_count", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
